// File: rtl/qracc_out_requant.sv
// qracc_out_requant
//   Requantizes accumulator vectors coming out of seq_acc and streams them to
//   the activation writeback path as outLanes-wide beats.
//
//   Each captured vector (numCols signed accumulators) is queued in a small
//   vector FIFO, because seq_acc cannot be stalled. The head vector is then
//   walked beat by beat. Every element is scaled, round-shifted, optionally
//   ReLU-clamped and saturated to outBits. Only outLanes multipliers exist;
//   a column mux feeds them from the beat being prepared.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   cfg_scale_i     unsigned scale factor
//   cfg_shift_i     right-shift amount 0..31
//   cfg_relu_i      clamp negative results to zero
//   acc_valid_i     one-cycle pulse qualifying acc_data_i
//   acc_data_i      packed [numCols-1:0][accBits-1:0] signed accumulators
//   full_o          vector FIFO full
//   out_valid_o     beat valid
//   out_ready_i     downstream accepts beat
//   out_data_o      lane j = column beat*outLanes+j
//   out_last_o      final beat of a vector
//   overflow_o      sticky: a vector was dropped because the FIFO was full
module qracc_out_requant #(
  parameter int numCols     = 32,
  parameter int accBits     = 16,
  parameter int outBits     = 8,
  parameter int outLanes    = 4,
  parameter int scaleBits   = 16,
  parameter int vectorDepth = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [scaleBits-1:0]          cfg_scale_i,
  input  logic [4:0]                    cfg_shift_i,
  input  logic                          cfg_relu_i,
  input  logic                          acc_valid_i,
  input  logic [numCols*accBits-1:0]    acc_data_i,
  output logic                          full_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [outLanes*outBits-1:0]   out_data_o,
  output logic                          out_last_o,
  output logic                          overflow_o
);

  localparam int NBEATS = numCols / outLanes;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PTR_W  = (vectorDepth > 1) ? $clog2(vectorDepth) : 1;
  localparam int CNT_W  = $clog2(vectorDepth + 1);
  localparam int PROD_W = accBits + scaleBits + 1;

  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'((2 ** (outBits - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-(2 ** (outBits - 1)));

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  // Round half toward +inf, then arithmetic shift. Headroom: |p| < 2^(PROD_W-2),
  // so adding a bias of at most 2^30 cannot wrap for the default widths.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] p,
    input logic [4:0]               sh
  );
    logic signed [PROD_W-1:0] one;
    logic signed [PROD_W-1:0] bias;
    one  = {{(PROD_W-1){1'b0}}, 1'b1};
    bias = (sh == 5'd0) ? '0 : (one <<< (sh - 5'd1));
    return (p + bias) >>> sh;
  endfunction

  function automatic logic signed [outBits-1:0] saturate(
    input logic signed [PROD_W-1:0] r,
    input logic                     relu
  );
    if (relu && (r < 0))  return '0;
    if (r > SAT_HI)       return SAT_HI[outBits-1:0];
    if (r < SAT_LO)       return SAT_LO[outBits-1:0];
    return r[outBits-1:0];
  endfunction

  function automatic logic signed [outBits-1:0] requant(
    input logic signed [accBits-1:0] a,
    input logic [scaleBits-1:0]      s,
    input logic [4:0]                sh,
    input logic                      relu
  );
    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] s_x;
    logic signed [PROD_W-1:0] p;
    a_x = PROD_W'(a);
    s_x = PROD_W'($signed({1'b0, s}));
    p   = a_x * s_x;
    return saturate(round_shift(p, sh), relu);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(vectorDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Vector FIFO storage (data only, never reset)
  logic [numCols-1:0][accBits-1:0] mem [vectorDepth];
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                cnt;

  state_t                          state;
  logic [BEAT_W-1:0]               beat;
  logic [scaleBits-1:0]            scale_r;
  logic [4:0]                      shift_r;
  logic                            relu_r;
  logic                            vld_p1;
  logic [outLanes-1:0][outBits-1:0] data_p1;
  logic                            overflow_r;

  logic                            full, accept, is_last, pop, push, drop;
  logic [BEAT_W-1:0]               sel_beat;
  logic [NBEATS-1:0][outLanes-1:0][accBits-1:0] head_beats;
  logic [outLanes-1:0][outBits-1:0] next_beat;

  assign full    = (cnt == CNT_W'(vectorDepth));
  assign accept  = vld_p1 && out_ready_i;
  assign is_last = (beat == BEAT_W'(NBEATS - 1));
  assign pop     = accept && is_last;
  // A write into a full FIFO is still taken when the head leaves on the same edge.
  assign push    = acc_valid_i && (!full || pop);
  assign drop    = acc_valid_i && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc_data_i;
  end

  // Stage p0: select the beat being prepared (beat 0 in LOAD, beat+1 while streaming)
  assign head_beats = mem[rd_ptr];
  assign sel_beat   = (state == LOAD) ? '0 : beat + 1'b1;

  for (genvar j = 0; j < outLanes; j++) begin : g_lane
    assign next_beat[j] = requant($signed(head_beats[sel_beat][j]), scale_r, shift_r, relu_r);
  end

  // Stage p1: registered output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      scale_r    <= '0;
      shift_r    <= '0;
      relu_r     <= 1'b0;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (drop) overflow_r <= 1'b1;

      case (state)
        IDLE: begin
          if (cnt != '0) begin
            scale_r <= cfg_scale_i;
            shift_r <= cfg_shift_i;
            relu_r  <= cfg_relu_i;
            beat    <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          data_p1 <= next_beat;
          vld_p1  <= 1'b1;
          state   <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            if (!is_last) begin
              beat    <= beat + 1'b1;
              data_p1 <= next_beat;
            end else begin
              beat   <= '0;
              vld_p1 <= 1'b0;
              // cnt still counts the head being popped; a same-edge push keeps it non-empty.
              if ((cnt > CNT_W'(1)) || push) begin
                scale_r <= cfg_scale_i;
                shift_r <= cfg_shift_i;
                relu_r  <= cfg_relu_i;
                state   <= LOAD;
              end else begin
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full_o      = full;
  assign out_valid_o = vld_p1;
  assign out_data_o  = data_p1;
  assign out_last_o  = vld_p1 && is_last;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_qracc_out_requant.sv
module tb_qracc_out_requant;

  localparam int NC = 32;
  localparam int AB = 16;
  localparam int OB = 8;
  localparam int OL = 4;
  localparam int SB = 16;
  localparam int NB = NC / OL;

  logic              clk = 1'b0;
  logic              rst;
  logic [SB-1:0]     cfg_scale;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic              acc_valid;
  logic [NC*AB-1:0]  acc_data;
  logic              full;
  logic              out_valid;
  logic              out_ready;
  logic [OL*OB-1:0]  out_data;
  logic              out_last;
  logic              overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int vec [NC];
  logic [31:0] rx_buf [NB];

  qracc_out_requant dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_scale_i (cfg_scale),
    .cfg_shift_i (cfg_shift),
    .cfg_relu_i  (cfg_relu),
    .acc_valid_i (acc_valid),
    .acc_data_i  (acc_data),
    .full_o      (full),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lin(input int base, input int stp);
    for (int k = 0; k < NC; k++) vec[k] = base + stp * k;
  endtask

  task automatic clear_vec();
    for (int k = 0; k < NC; k++) vec[k] = 0;
  endtask

  task automatic pack_vec();
    for (int k = 0; k < NC; k++) acc_data[k*AB +: AB] = AB'(vec[k]);
  endtask

  // One-cycle valid pulse; returns #1 after the capturing edge.
  task automatic pulse_vec();
    pack_vec();
    acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
  endtask

  function automatic logic [31:0] exp_lin(input int base, input int stp, input int b);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < OL; j++) r[j*OB +: OB] = OB'(base + stp * (b * OL + j));
    return r;
  endfunction

  // Waits (bounded) for a valid beat, records it, lets it be accepted (ready must be 1).
  task automatic recv_beat(input string tag, output logic [31:0] d, output logic l, output int waited);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    if (out_valid !== 1'b1) begin
      check_eq({tag, " timeout"}, 32'd0, 32'd1);
      d = '0;
      l = 1'b0;
    end else begin
      d = out_data;
      l = out_last;
      step();
    end
  endtask

  task automatic rx_range(input string tag, input int base, input int stp, input int first, input int last_b);
    logic [31:0] d;
    logic        l;
    int          w;
    for (int b = first; b <= last_b; b++) begin
      recv_beat(tag, d, l, w);
      check_eq($sformatf("%s data b%0d", tag, b), d, exp_lin(base, stp, b));
      check_eq($sformatf("%s last b%0d", tag, b), {31'd0, l}, {31'd0, b == NB - 1});
      if (b > first) check_eq($sformatf("%s bubble b%0d", tag, b), w, 32'd0);
    end
  endtask

  task automatic rx_all(input string tag);
    logic l;
    int   w;
    for (int b = 0; b < NB; b++) recv_beat(tag, rx_buf[b], l, w);
  endtask

  // Called #1 after the capturing edge of an idle block.
  task automatic check_latency(input string tag);
    check_eq({tag, " lat E"}, {31'd0, out_valid}, 32'd0);
    step();
    check_eq({tag, " lat E+1"}, {31'd0, out_valid}, 32'd0);
    step();
    check_eq({tag, " lat E+2"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    int seen;
    seen = 0;
    repeat (6) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    check_eq({tag, " no extra beats"}, seen, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] d0;
    logic        l0;
    logic        stable;
    int          w;

    rst = 1'b1; acc_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
    cfg_scale = 16'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
    clear_vec();
    step(); step();
    check_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst out_data",  out_data, 32'd0);
    check_eq("rst out_last",  {31'd0, out_last}, 32'd0);
    check_eq("rst full",      {31'd0, full}, 32'd0);
    check_eq("rst overflow",  {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    step();

    // 1: identity
    set_lin(-16, 1);
    pulse_vec();
    check_latency("t1");
    rx_range("t1", -16, 1, 0, NB - 1);
    check_eq("t1 idle after", {31'd0, out_valid}, 32'd0);

    // 2: rounding and saturation
    cfg_shift = 5'd1;
    clear_vec(); vec[0] = 3; vec[1] = -3; vec[2] = 1; vec[3] = -1;
    pulse_vec();
    rx_all("t2a");
    check_eq("t2 round", rx_buf[0], 32'h0001FF02);
    cfg_shift = 5'd0;
    clear_vec(); vec[0] = 1000; vec[1] = -1000; vec[2] = 127; vec[3] = -128;
    pulse_vec();
    rx_all("t2b");
    check_eq("t2 sat", rx_buf[0], 32'h807F807F);

    // 3: ReLU + scale, cfg changed after latch must not affect this vector
    cfg_relu = 1'b1; cfg_scale = 16'd3; cfg_shift = 5'd2;
    clear_vec(); vec[0] = -5; vec[1] = 5; vec[2] = 40; vec[3] = 200;
    vec[4] = 8; vec[5] = -8; vec[6] = -1; vec[7] = 1;
    pulse_vec();
    step();
    cfg_relu = 1'b0; cfg_scale = 16'd1; cfg_shift = 5'd0;
    rx_all("t3");
    check_eq("t3 relu b0", rx_buf[0], 32'h7F1E0400);
    check_eq("t3 cfg hold b1", rx_buf[1], 32'h01000006);

    // 4: backpressure mid-vector
    set_lin(-16, 1);
    pulse_vec();
    rx_range("t4a", -16, 1, 0, 2);
    out_ready = 1'b0;
    d0 = out_data; l0 = out_last;
    check_eq("t4 held valid", {31'd0, out_valid}, 32'd1);
    check_eq("t4 held beat", d0, exp_lin(-16, 1, 3));
    stable = 1'b1;
    repeat (10) begin
      step();
      if (out_data !== d0 || out_last !== l0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check_eq("t4 stable", {31'd0, stable}, 32'd1);
    out_ready = 1'b1;
    rx_range("t4b", -16, 1, 3, NB - 1);

    // 5: overrun
    out_ready = 1'b0;
    set_lin(0, 1);   pulse_vec(); step();
    set_lin(-1, -1); pulse_vec();
    check_eq("t5 full", {31'd0, full}, 32'd1);
    check_eq("t5 no ovf yet", {31'd0, overflow}, 32'd0);
    step();
    set_lin(60, 1);  pulse_vec();
    check_eq("t5 ovf", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    rx_range("t5 v1", 0, 1, 0, NB - 1);
    rx_range("t5 v2", -1, -1, 0, NB - 1);
    check_quiet("t5");
    check_eq("t5 not full", {31'd0, full}, 32'd0);
    check_eq("t5 ovf sticky", {31'd0, overflow}, 32'd1);

    // 6: asynchronous reset mid-stream with a vector queued
    out_ready = 1'b0;
    set_lin(-16, 1); pulse_vec(); step();
    set_lin(40, 1);  pulse_vec();
    out_ready = 1'b1;
    rx_range("t6a", -16, 1, 0, 2);
    rst = 1'b1;
    #1;
    check_eq("t6 rst valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6 rst data",  out_data, 32'd0);
    check_eq("t6 rst last",  {31'd0, out_last}, 32'd0);
    check_eq("t6 rst full",  {31'd0, full}, 32'd0);
    check_eq("t6 rst ovf",   {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet("t6 flushed");
    set_lin(50, 1);
    pulse_vec();
    check_latency("t6");
    rx_range("t6b", 50, 1, 0, NB - 1);
    check_quiet("t6b");

    // 5b: push on the same edge as a last-beat pop while full
    out_ready = 1'b0;
    set_lin(0, 1);   pulse_vec(); step();
    set_lin(-1, -1); pulse_vec();
    check_eq("t5b full", {31'd0, full}, 32'd1);
    out_ready = 1'b1;
    rx_range("t5b v1", 0, 1, 0, NB - 2);
    set_lin(60, 1);
    pack_vec();
    acc_valid = 1'b1;
    recv_beat("t5b pop", d0, l0, w);
    acc_valid = 1'b0;
    check_eq("t5b pop data", d0, exp_lin(0, 1, NB - 1));
    check_eq("t5b pop last", {31'd0, l0}, 32'd1);
    check_eq("t5b no ovf", {31'd0, overflow}, 32'd0);
    check_eq("t5b still full", {31'd0, full}, 32'd1);
    rx_range("t5b v2", -1, -1, 0, NB - 1);
    rx_range("t5b v3", 60, 1, 0, NB - 1);
    check_quiet("t5b");
    check_eq("t5b ovf end", {31'd0, overflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
